// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the MIPS datapath (slave):
// IR fields and status flags flow in, enables/mux selects and debug status flow out.
interface multicycle_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       v0_is_exit;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       mem_read;
  logic       mem_addr_sel;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src;
  logic [2:0] alu_op;
  logic [2:0] state;
  logic       halted;
  logic       error;

  modport master (
    input  opcode, funct, zero, mem_ready, v0_is_exit,
    output ir_write, pc_write, pc_src, mem_read, mem_addr_sel, mem_write,
    output reg_write, reg_dst, mem_to_reg, alu_src, alu_op, state, halted, error
  );

  modport slave (
    output opcode, funct, zero, mem_ready, v0_is_exit,
    input  ir_write, pc_write, pc_src, mem_read, mem_addr_sel, mem_write,
    input  reg_write, reg_dst, mem_to_reg, alu_src, alu_op, state, halted, error
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM; 2-5 cycles per instruction plus memory wait cycles.
// Memory requests hold until mem_ready; MEM_TIMEOUT idle-wait cycles halt with error.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic                   clock,
  input logic                   reset_n,
  multicycle_sequencer_if.master bus
);
  localparam int             CW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23,
                         OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C, FN_ADD = 6'h20, FN_SUB = 6'h22,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR = 3'b001, ALU_SLT = 3'b111;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_set;
  logic          ir_write_c, pc_write_c, mem_read_c, mem_addr_sel_c, mem_write_c;
  logic          reg_write_c, alu_src_c;
  logic [1:0]    pc_src_c, reg_dst_c, mem_to_reg_c;
  logic [2:0]    alu_op_c, funct_alu_op;
  logic          funct_alu, is_rtype, wait_expired;

  assign is_rtype     = (bus.opcode == OP_SPECIAL);
  assign wait_expired = !bus.mem_ready && (cnt_q == CNT_MAX);

  always_comb begin
    funct_alu    = 1'b1;
    funct_alu_op = ALU_ADD;
    case (bus.funct)
      FN_ADD:  funct_alu_op = ALU_ADD;
      FN_SUB:  funct_alu_op = ALU_SUB;
      FN_AND:  funct_alu_op = ALU_AND;
      FN_OR:   funct_alu_op = ALU_OR;
      FN_SLT:  funct_alu_op = ALU_SLT;
      default: funct_alu    = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    error_set      = 1'b0;
    ir_write_c     = 1'b0;
    pc_write_c     = 1'b0;
    pc_src_c       = 2'd0;
    mem_read_c     = 1'b0;
    mem_addr_sel_c = 1'b0;
    mem_write_c    = 1'b0;
    reg_write_c    = 1'b0;
    reg_dst_c      = 2'd0;
    mem_to_reg_c   = 2'd0;
    alu_src_c      = 1'b0;
    alu_op_c       = 3'b000;
    case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = DECODE;
        end else if (wait_expired) begin
          state_d   = HALT;
          error_set = 1'b1;
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_J: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'd2;
            state_d    = FETCH;
          end
          OP_JAL: begin
            // PC already holds PC+4 from FETCH, so it is the link value
            pc_write_c   = 1'b1;
            pc_src_c     = 2'd2;
            reg_write_c  = 1'b1;
            reg_dst_c    = 2'd2;
            mem_to_reg_c = 2'd2;
            state_d      = FETCH;
          end
          OP_SPECIAL: begin
            if (funct_alu) begin
              state_d = EXEC;
            end else if (bus.funct == FN_JR) begin
              pc_write_c = 1'b1;
              pc_src_c   = 2'd3;
              state_d    = FETCH;
            end else if (bus.funct == FN_SYSCALL) begin
              state_d = bus.v0_is_exit ? HALT : FETCH;
            end else begin
              state_d   = HALT;
              error_set = 1'b1;
            end
          end
          OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = EXEC;
          default: begin
            state_d   = HALT;
            error_set = 1'b1;
          end
        endcase
      end
      EXEC: begin
        case (bus.opcode)
          OP_SPECIAL: begin
            alu_op_c = funct_alu_op;
            state_d  = WB;
          end
          OP_ADDI: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_ADD;
            state_d   = WB;
          end
          OP_ORI: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_OR;
            state_d   = WB;
          end
          OP_LW, OP_SW: begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_ADD;
            state_d   = MEM;
          end
          OP_BEQ, OP_BNE: begin
            alu_op_c   = ALU_SUB;
            pc_src_c   = 2'd1;
            pc_write_c = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
            state_d    = FETCH;
          end
          default: begin
            state_d   = HALT;
            error_set = 1'b1;
          end
        endcase
      end
      MEM: begin
        mem_addr_sel_c = 1'b1;
        alu_src_c      = 1'b1;
        alu_op_c       = ALU_ADD;
        mem_read_c     = (bus.opcode == OP_LW);
        mem_write_c    = (bus.opcode == OP_SW);
        if (bus.mem_ready && bus.opcode == OP_LW) begin
          state_d = WB;
        end else if (bus.mem_ready && bus.opcode == OP_SW) begin
          state_d = FETCH;
        end else if (wait_expired) begin
          state_d   = HALT;
          error_set = 1'b1;
        end
      end
      WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = is_rtype ? 2'd1 : 2'd0;
        mem_to_reg_c = (bus.opcode == OP_LW) ? 2'd1 : 2'd0;
        state_d      = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // The counter only advances while a memory state is held waiting; any transition clears it.
  always_comb begin
    cnt_d = '0;
    if ((state_q == FETCH || state_q == MEM) && state_d == state_q)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (error_set)
        error_q <= 1'b1;
    end
  end

  assign bus.ir_write     = reset_n & ir_write_c;
  assign bus.pc_write     = reset_n & pc_write_c;
  assign bus.pc_src       = reset_n ? pc_src_c : 2'd0;
  assign bus.mem_read     = reset_n & mem_read_c;
  assign bus.mem_addr_sel = reset_n & mem_addr_sel_c;
  assign bus.mem_write    = reset_n & mem_write_c;
  assign bus.reg_write    = reset_n & reg_write_c;
  assign bus.reg_dst      = reset_n ? reg_dst_c : 2'd0;
  assign bus.mem_to_reg   = reset_n ? mem_to_reg_c : 2'd0;
  assign bus.alu_src      = reset_n & alu_src_c;
  assign bus.alu_op       = reset_n ? alu_op_c : 3'b000;
  assign bus.state        = state_q;
  assign bus.halted       = (state_q == HALT);
  assign bus.error        = error_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed scenarios plus a randomized instruction stream
// with random memory wait cycles, compared against an instruction-level latency/effect model.
module tb_multicycle_sequencer;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  multicycle_sequencer_if bus ();
  multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_addr_sel;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
  } ctl_t;

  int checks = 0;
  int errors = 0;

  logic [5:0] pool_op [15] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] pool_fn [15] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h0C,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  function automatic ctl_t get_ctl();
    ctl_t c;
    c.ir_write     = bus.ir_write;
    c.pc_write     = bus.pc_write;
    c.pc_src       = bus.pc_src;
    c.mem_read     = bus.mem_read;
    c.mem_addr_sel = bus.mem_addr_sel;
    c.mem_write    = bus.mem_write;
    c.reg_write    = bus.reg_write;
    c.reg_dst      = bus.reg_dst;
    c.mem_to_reg   = bus.mem_to_reg;
    c.alu_src      = bus.alu_src;
    c.alu_op       = bus.alu_op;
    return c;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  // Instruction-level view: what one instruction costs and what it does, from the ISA rules.
  function automatic void model(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                input int wf, input int wm,
                                output int cyc_n, output int pcw_n, output int rw_n,
                                output int mw_n, output logic [1:0] dst, output logic [1:0] m2r,
                                output logic [1:0] pcs, output logic [2:0] alu,
                                output bit has_exec, output bit extra_pc);
    bit r, imm, lw, sw, br, jal, jmp;
    r   = (op == 6'h00) && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
    imm = op inside {6'h08, 6'h0D};
    lw  = (op == 6'h23);
    sw  = (op == 6'h2B);
    br  = op inside {6'h04, 6'h05};
    jal = (op == 6'h03);
    jmp = (op inside {6'h02, 6'h03}) || (op == 6'h00 && fn == 6'h08);
    has_exec = r || imm || lw || sw || br;
    cyc_n = (r || imm || sw) ? 4 : lw ? 5 : br ? 3 : 2;
    cyc_n += wf + ((lw || sw) ? wm : 0);
    extra_pc = jmp || (op == 6'h04 && z) || (op == 6'h05 && !z);
    pcw_n = 1 + (extra_pc ? 1 : 0);
    pcs   = br ? 2'd1 : (op == 6'h00) ? 2'd3 : 2'd2;
    rw_n  = (r || imm || lw || jal) ? 1 : 0;
    mw_n  = sw ? 1 : 0;
    dst   = r ? 2'd1 : jal ? 2'd2 : 2'd0;
    m2r   = lw ? 2'd1 : jal ? 2'd2 : 2'd0;
    alu   = 3'b000;
    if (r) begin
      case (fn)
        6'h20:   alu = 3'b010;
        6'h22:   alu = 3'b110;
        6'h24:   alu = 3'b000;
        6'h25:   alu = 3'b001;
        default: alu = 3'b111;
      endcase
    end else if (op == 6'h08 || lw || sw) begin
      alu = 3'b010;
    end else if (op == 6'h0D) begin
      alu = 3'b001;
    end else if (br) begin
      alu = 3'b110;
    end
  endfunction

  task automatic test_reset();
    ctl_t e;
    reset_n = 1'b0;
    bus.opcode = 6'h2B;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    bus.v0_is_exit = 1'b0;
    cyc();
    #1;
    checks++;
    if (get_ctl() !== '0) begin
      errors++;
      $display("FAIL reset_ctl got %h want 0", get_ctl());
    end
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", bus.state);
    end
    checks++;
    if (bus.halted !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got halted=%b error=%b want 0 0", bus.halted, bus.error);
    end
    reset_n = 1'b1;
    #1;
    e = '0;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    e.mem_read = 1'b1;
    checks++;
    if (get_ctl() !== e) begin
      errors++;
      $display("FAIL reset_release_fetch got %h want %h", get_ctl(), e);
    end
  endtask

  task automatic test_add();
    ctl_t e [5];
    logic [2:0] es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    foreach (e[i]) e[i] = '0;
    e[0].mem_read = 1'b1; e[0].ir_write = 1'b1; e[0].pc_write = 1'b1;
    e[2].alu_op = 3'b010;
    e[3].reg_write = 1'b1; e[3].reg_dst = 2'd1;
    e[4] = e[0];
    do_reset();
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.state !== es[i]) begin
        errors++;
        $display("FAIL add_state cyc%0d got %0d want %0d", i, bus.state, es[i]);
      end
      checks++;
      if (get_ctl() !== e[i]) begin
        errors++;
        $display("FAIL add_ctl cyc%0d got %h want %h", i, get_ctl(), e[i]);
      end
      cyc();
    end
  endtask

  task automatic test_lw_wait();
    ctl_t e [9];
    logic [2:0] es [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic mr [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    foreach (e[i]) e[i] = '0;
    e[0].mem_read = 1'b1; e[0].ir_write = 1'b1; e[0].pc_write = 1'b1;
    e[2].alu_src = 1'b1; e[2].alu_op = 3'b010;
    for (int i = 3; i < 7; i++) begin
      e[i].mem_read = 1'b1; e[i].mem_addr_sel = 1'b1; e[i].alu_src = 1'b1; e[i].alu_op = 3'b010;
    end
    e[7].reg_write = 1'b1; e[7].mem_to_reg = 2'd1;
    e[8] = e[0];
    do_reset();
    bus.opcode = 6'h23; bus.funct = 6'h00;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = mr[i];
      #1;
      checks++;
      if (bus.state !== es[i] || get_ctl() !== e[i]) begin
        errors++;
        $display("FAIL lw_cycle cyc%0d got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, bus.state, get_ctl(), es[i], e[i]);
      end
      cyc();
    end
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL lw_error got %b want 0", bus.error);
    end
  endtask

  task automatic test_branch();
    ctl_t e;
    do_reset();
    bus.mem_ready = 1'b1;
    bus.zero = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.opcode = (k == 0) ? 6'h04 : 6'h05;
      cyc();
      cyc();
      #1;
      e = '0;
      e.alu_op = 3'b110;
      e.pc_src = 2'd1;
      e.pc_write = (k == 0);
      checks++;
      if (bus.state !== 3'd2 || get_ctl() !== e) begin
        errors++;
        $display("FAIL branch_exec op%0d got state=%0d ctl=%h want state=2 ctl=%h",
                 k, bus.state, get_ctl(), e);
      end
      cyc();
      checks++;
      if (bus.state !== 3'd0) begin
        errors++;
        $display("FAIL branch_return op%0d got %0d want 0", k, bus.state);
      end
    end
  endtask

  task automatic test_jal();
    ctl_t e;
    do_reset();
    bus.opcode = 6'h03; bus.mem_ready = 1'b1;
    cyc();
    #1;
    e = '0;
    e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
    checks++;
    if (bus.state !== 3'd1 || get_ctl() !== e) begin
      errors++;
      $display("FAIL jal_decode got state=%0d ctl=%h want state=1 ctl=%h", bus.state, get_ctl(), e);
    end
    cyc();
    checks++;
    if (bus.state !== 3'd0) begin
      errors++;
      $display("FAIL jal_return got %0d want 0", bus.state);
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    bus.opcode = 6'h00; bus.funct = 6'h20; bus.mem_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.state !== 3'd0 || bus.mem_read !== 1'b1) bad++;
      cyc();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_wait got %0d bad cycles want 0", bad);
    end
    #1;
    checks++;
    if (bus.state !== 3'd5 || bus.halted !== 1'b1 || bus.error !== 1'b1 || get_ctl() !== '0) begin
      errors++;
      $display("FAIL timeout_halt got state=%0d halted=%b error=%b ctl=%h want 5 1 1 0",
               bus.state, bus.halted, bus.error, get_ctl());
    end
    bus.mem_ready = 1'b1;
    cyc();
    #1;
    checks++;
    if (bus.state !== 3'd5 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_absorb got state=%0d halted=%b want 5 1", bus.state, bus.halted);
    end
    do_reset();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (bus.ir_write !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ready_irw got %b want 1", bus.ir_write);
    end
    cyc();
    #1;
    checks++;
    if (bus.state !== 3'd1 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_ready_wins got state=%0d error=%b want 1 0", bus.state, bus.error);
    end
  endtask

  task automatic test_halt_cases();
    logic [5:0] ops [4] = '{6'h00, 6'h00, 6'h3F, 6'h00};
    logic [5:0] fns [4] = '{6'h0C, 6'h0C, 6'h00, 6'h01};
    logic       v0s [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] ws  [4] = '{3'd5, 3'd0, 3'd5, 3'd5};
    logic       we  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      bus.opcode = ops[k]; bus.funct = fns[k]; bus.v0_is_exit = v0s[k]; bus.mem_ready = 1'b1;
      cyc();
      cyc();
      #1;
      checks++;
      if (bus.state !== ws[k] || bus.error !== we[k] || bus.halted !== (ws[k] == 3'd5)) begin
        errors++;
        $display("FAIL halt_case%0d got state=%0d error=%b halted=%b want %0d %b",
                 k, bus.state, bus.error, bus.halted, ws[k], we[k]);
      end
    end
    bus.v0_is_exit = 1'b0;
    do_reset();
    #1;
    checks++;
    if (bus.error !== 1'b0 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL error_clear got error=%b halted=%b want 0 0", bus.error, bus.halted);
    end
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    bus.mem_ready = 1'b0;
    #1;
    checks++;
    if (bus.state !== 3'd3 || bus.mem_write !== 1'b1 || bus.mem_addr_sel !== 1'b1) begin
      errors++;
      $display("FAIL sw_mem got state=%0d mem_write=%b want 3 1", bus.state, bus.mem_write);
    end
    cyc();
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (get_ctl() !== '0) begin
      errors++;
      $display("FAIL sw_reset_ctl got %h want 0", get_ctl());
    end
    cyc();
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin
      errors++;
      $display("FAIL sw_reset_state got state=%0d rd=%b wr=%b want 0 1 0",
               bus.state, bus.mem_read, bus.mem_write);
    end
  endtask

  task automatic test_random();
    int idx, wf, wm, left, n_cyc, n_irw, n_pcw, n_rw, n_mw;
    int x_cyc, x_pcw, x_rw, x_mw;
    bit z, req, prev_req, seen_nf, has_exec, extra_pc;
    logic [1:0] x_dst, x_m2r, x_pcs, g_dst, g_m2r, g_pcs;
    logic [2:0] x_alu, g_alu;
    do_reset();
    bus.v0_is_exit = 1'b0;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 14);
      z = ($urandom_range(0, 1) != 0);
      wf = $urandom_range(0, 4);
      wm = $urandom_range(0, 4);
      bus.opcode = pool_op[idx];
      bus.funct = (pool_op[idx] == 6'h00) ? pool_fn[idx] : 6'($urandom_range(0, 63));
      bus.zero = z;
      model(bus.opcode, bus.funct, z, wf, wm, x_cyc, x_pcw, x_rw, x_mw,
            x_dst, x_m2r, x_pcs, x_alu, has_exec, extra_pc);
      n_cyc = 0; n_irw = 0; n_pcw = 0; n_rw = 0; n_mw = 0;
      g_dst = '0; g_m2r = '0; g_pcs = '0; g_alu = '0;
      left = wf; prev_req = 1'b0; seen_nf = 1'b0;
      do begin
        #1;
        req = bus.mem_read | bus.mem_write;
        if (req && !prev_req && n_cyc > 0) left = wm;
        bus.mem_ready = req && (left == 0);
        if (req && left > 0) left--;
        #1;
        if (bus.ir_write) n_irw++;
        if (bus.pc_write) begin
          n_pcw++;
          if (!bus.ir_write) g_pcs = bus.pc_src;
        end
        if (bus.reg_write) begin
          n_rw++;
          g_dst = bus.reg_dst;
          g_m2r = bus.mem_to_reg;
        end
        if (bus.mem_write && bus.mem_ready) n_mw++;
        if (bus.state == 3'd2) g_alu = bus.alu_op;
        prev_req = req;
        n_cyc++;
        cyc();
        if (bus.state != 3'd0) seen_nf = 1'b1;
      end while (!(seen_nf && bus.state == 3'd0) && n_cyc < 40);
      checks++;
      if (n_cyc !== x_cyc) begin
        errors++;
        $display("FAIL rand_latency n%0d op=%h fn=%h got %0d want %0d",
                 n, bus.opcode, bus.funct, n_cyc, x_cyc);
      end
      checks++;
      if (n_irw !== 1 || n_pcw !== x_pcw || n_rw !== x_rw || n_mw !== x_mw) begin
        errors++;
        $display("FAIL rand_writes n%0d op=%h got irw=%0d pcw=%0d rw=%0d mw=%0d want 1 %0d %0d %0d",
                 n, bus.opcode, n_irw, n_pcw, n_rw, n_mw, x_pcw, x_rw, x_mw);
      end
      if (x_rw != 0) begin
        checks++;
        if (g_dst !== x_dst || g_m2r !== x_m2r) begin
          errors++;
          $display("FAIL rand_wb n%0d op=%h got dst=%0d m2r=%0d want %0d %0d",
                   n, bus.opcode, g_dst, g_m2r, x_dst, x_m2r);
        end
      end
      if (extra_pc) begin
        checks++;
        if (g_pcs !== x_pcs) begin
          errors++;
          $display("FAIL rand_pc_src n%0d op=%h got %0d want %0d", n, bus.opcode, g_pcs, x_pcs);
        end
      end
      if (has_exec) begin
        checks++;
        if (g_alu !== x_alu) begin
          errors++;
          $display("FAIL rand_alu n%0d op=%h fn=%h got %b want %b",
                   n, bus.opcode, bus.funct, g_alu, x_alu);
        end
      end
      checks++;
      if (bus.error !== 1'b0) begin
        errors++;
        $display("FAIL rand_error n%0d got %b want 0", n, bus.error);
      end
      if (n_cyc >= 40 || bus.error !== 1'b0) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jal();
    test_timeout();
    test_halt_cases();
    test_reset_mid_sw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
